// File: rtl/shift_chain_ctrl.sv
// shift_chain_ctrl: serialises a parallel word MSB-first into an external
// DFF chain, then reassembles the word from the bits that return from the
// chain and holds it for the consumer until it is accepted.
module shift_chain_ctrl #(
   parameter int WIDTH       = 8,
   parameter int CHAIN_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             sd_out,
   input  logic             sd_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + CHAIN_DEPTH + 1);

   localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] LAST_FLUSH = CW'(WIDTH + CHAIN_DEPTH - 1);
   localparam logic [CW-1:0] FIRST_CAP  = CW'(CHAIN_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FLUSH,
      DONE
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   // Latched word, pre-shifted so its top bit is always the next bit to send.
   logic [WIDTH-1:0] word_q;

   // Transfer sequencer: state, counter, serial output and capture register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         word_q    <= '0;
         sd_out    <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  // MSB goes out in the first SHIFT cycle; the rest queue up.
                  sd_out   <= in_data[WIDTH-1];
                  word_q   <= in_data << 1;
                  cnt      <= '0;
                  out_data <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end

            SHIFT: begin
               cnt    <= cnt + CW'(1);
               word_q <= word_q << 1;
               if (cnt == LAST_SHIFT) begin
                  sd_out <= 1'b0;
                  state  <= FLUSH;
               end else begin
                  sd_out <= word_q[WIDTH-1];
               end
               if (cnt >= FIRST_CAP) begin
                  out_data <= {out_data[WIDTH-2:0], sd_in};
               end
            end

            FLUSH: begin
               cnt    <= cnt + CW'(1);
               sd_out <= 1'b0;
               if (cnt >= FIRST_CAP) begin
                  out_data <= {out_data[WIDTH-2:0], sd_in};
               end
               if (cnt == LAST_FLUSH) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end

            DONE: begin
               sd_out <= 1'b0;
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               sd_out    <= 1'b0;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// tb_shift_chain_ctrl: drives shift_chain_ctrl through a DFF chain model and
// checks serial bits, latency, handshakes, reset abort and data integrity.
module tb_shift_chain_ctrl;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         sd_out;
   logic         sd_in;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         busy;

   logic [D-1:0] chain = '0;
   logic         invert = 1'b0;
   int unsigned  cyc = 0;
   int unsigned  n_chk = 0;
   int unsigned  n_fail = 0;

   shift_chain_ctrl #(.WIDTH(W), .CHAIN_DEPTH(D)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .sd_out    (sd_out),
      .sd_in     (sd_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // External serial chain: D flops, optional inverter at the far end.
   always @(posedge clk) chain <= {chain[D-2:0], sd_out};
   assign sd_in = chain[D-1] ^ invert;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete transfer, checked cycle by cycle from the word itself.
   // bp: DONE cycles with out_ready low; noisy: random in_valid/in_data while
   // busy; hold_ff: keep in_valid=1 with in_data=FF while busy.
   task automatic send(input logic [W-1:0] word, input int unsigned bp,
                       input logic noisy, input logic hold_ff,
                       output int unsigned done_at);
      logic [W-1:0] exp;
      exp = invert ? ~word : word;
      chk("idle_ready", in_ready, 1);
      chk("idle_busy", busy, 0);
      out_ready = (bp == 0);
      in_valid = 1'b1;
      in_data  = word;
      @(negedge clk);
      for (int k = 0; k < W; k++) begin
         if (hold_ff) begin in_valid = 1'b1; in_data = 8'hFF; end
         else if (noisy) begin in_valid = 1'($urandom); in_data = W'($urandom); end
         else in_valid = 1'b0;
         chk("shift_sd_out", sd_out, word[W-1-k]);
         chk("shift_busy", busy, 1);
         chk("shift_ready", in_ready, 0);
         chk("shift_valid", out_valid, 0);
         @(negedge clk);
      end
      for (int f = 0; f < D; f++) begin
         if (noisy && !hold_ff) begin in_valid = 1'($urandom); in_data = W'($urandom); end
         chk("flush_sd_out", sd_out, 0);
         chk("flush_valid", out_valid, 0);
         chk("flush_busy", busy, 1);
         @(negedge clk);
      end
      done_at = cyc;
      for (int i = 0; i <= int'(bp); i++) begin
         if (noisy && !hold_ff) begin in_valid = 1'($urandom); in_data = W'($urandom); end
         chk("done_valid", out_valid, 1);
         chk("done_data", out_data, exp);
         chk("done_ready", in_ready, 0);
         chk("done_sd_out", sd_out, 0);
         if (i == int'(bp)) out_ready = 1'b1;
         @(negedge clk);
      end
      chk("back_idle_busy", busy, 0);
      chk("back_idle_valid", out_valid, 0);
      chk("back_idle_ready", in_ready, 1);
      chk("back_idle_sd_out", sd_out, 0);
      if (!hold_ff) in_valid = 1'b0;
   endtask

   initial begin
      int unsigned t1, t2;

      // Reset state
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", in_ready, 1);
      chk("rst_sd_out", sd_out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      rstn = 1'b1;
      @(negedge clk);

      // Loopback 0xA5, then backpressure 0x3C
      send(8'hA5, 0, 1'b0, 1'b0, t1);
      send(8'h3C, 5, 1'b0, 1'b0, t1);

      // Busy ignore: FF held during 0x01, accepted in next IDLE cycle
      send(8'h01, 0, 1'b0, 1'b1, t1);
      send(8'hFF, 0, 1'b0, 1'b0, t2);
      chk("ignore_spacing", t2 - t1, W + D + 2);

      // Reset mid-SHIFT at cycle 3 of 0xF0
      in_valid = 1'b1;
      in_data  = 8'hF0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_busy_pre", busy, 1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("abort_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_data", out_data, 0);
      chk("abort_sd_out", sd_out, 0);
      for (int i = 0; i < W + D + 2; i++) begin
         @(negedge clk);
         chk("abort_no_valid", out_valid, 0);
         chk("abort_stay_idle", busy, 0);
      end
      send(8'h81, 0, 1'b0, 1'b0, t1);

      // Corrupted chain
      invert = 1'b1;
      send(8'hA5, 0, 1'b0, 1'b0, t1);
      invert = 1'b0;

      // Back-to-back 0x00 then 0xFF
      send(8'h00, 0, 1'b0, 1'b1, t1);
      send(8'hFF, 0, 1'b0, 1'b0, t2);
      chk("b2b_spacing", t2 - t1, W + D + 2);

      // Random words, random backpressure, random noise on the input side
      for (int n = 0; n < 16; n++) begin
         send(W'($urandom), $urandom_range(0, 3), 1'b1, 1'b0, t1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_chain_ctrl.md
SHIFT_CHAIN_CTRL -- requirements
Module: shift_chain_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits; legal values are WIDTH >= 2.
REQ-002 The block SHALL have parameter CHAIN_DEPTH, default 4, giving the number of DFF stages in the external serial chain; legal values are CHAIN_DEPTH >= 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rstn  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  a parallel word is offered on in_data.
REQ-006 in_ready  output  1  the block can accept a word.
REQ-007 in_data  input  WIDTH  parallel word to send through the chain.
REQ-008 sd_out  output  1  serial bit driven into the chain's first stage.
REQ-009 sd_in  input  1  serial bit returned from the chain's last stage.
REQ-010 out_valid  output  1  out_data holds a completed captured word.
REQ-011 out_ready  input  1  the consumer accepts out_data.
REQ-012 out_data  output  WIDTH  word reassembled from sd_in.
REQ-013 busy  output  1  the block is not in IDLE.

Function
REQ-014 The block SHALL implement four states: IDLE, SHIFT, FLUSH and DONE.
REQ-015 IDLE: in_ready=1; a handshake (in_valid & in_ready) in cycle T SHALL latch in_data, clear the counter, and enter SHIFT at T+1; otherwise the block stays in IDLE.
REQ-016 SHIFT: during SHIFT cycle k (k=0..WIDTH-1), sd_out SHALL equal latched word bit [WIDTH-1-k], so the MSB goes first; after cycle WIDTH-1 the block enters FLUSH.
REQ-017 FLUSH: the block SHALL hold sd_out=0 for exactly CHAIN_DEPTH cycles, then enter DONE.
REQ-018 A single counter SHALL count active cycles c=0..WIDTH+CHAIN_DEPTH-1, with c=0 being the first SHIFT cycle; its width SHALL be clog2(WIDTH+CHAIN_DEPTH+1).
REQ-019 Capture: at the end of each active cycle with c >= CHAIN_DEPTH, the block SHALL shift out_data left by one and insert sd_in at the LSB, giving exactly WIDTH captures in total.
REQ-020 The capture register SHALL be cleared on entry to SHIFT.
REQ-021 DONE: out_valid=1 and out_data stable; the block SHALL hold DONE until out_ready=1, then return to IDLE in the next cycle.
REQ-022 With an ideal chain, latency SHALL be WIDTH+CHAIN_DEPTH cycles from the first SHIFT cycle to the first DONE cycle, and out_data SHALL equal the word sent.
REQ-023 in_ready SHALL be 0 in SHIFT, FLUSH and DONE; in_valid in those states SHALL be ignored and SHALL NOT disturb the transfer in progress.
REQ-024 If out_ready and in_valid are both high in DONE, no new word SHALL be accepted; the earliest next acceptance is the following IDLE cycle.
REQ-025 busy SHALL be 1 exactly when the state is not IDLE.
REQ-026 sd_out SHALL be 0 in IDLE, FLUSH and DONE.

Reset
REQ-027 When rstn=0 at a rising edge, the block SHALL enter IDLE in any state, including mid-SHIFT or mid-FLUSH, and abandon the transfer in progress.
REQ-028 Reset values SHALL be: in_ready=1, sd_out=0, out_valid=0, out_data=0, busy=0, counter=0, latched word=0.
REQ-029 No out_valid pulse SHALL result from an aborted transfer.

Verification (bench uses a 4-stage DFF chain model between sd_out and sd_in; defaults WIDTH=8, CHAIN_DEPTH=4)
REQ-030 Loopback: send 0xA5 with out_ready=1 -> sd_out shows 1,0,1,0,0,1,0,1 over SHIFT cycles 0-7; out_valid rises 12 cycles after the first SHIFT cycle with out_data=0xA5; the block is in IDLE one cycle later.
REQ-031 Backpressure: send 0x3C with out_ready=0 for 5 cycles after DONE -> out_valid stays 1 and out_data=0x3C is stable throughout; the block returns to IDLE the cycle after out_ready=1.
REQ-032 Busy ignore: hold in_valid=1 with in_data=0xFF during a transfer of 0x01 -> out_data=0x01; 0xFF is accepted only in the next IDLE cycle.
REQ-033 Reset mid-SHIFT: assert rstn=0 at SHIFT cycle 3 of 0xF0 -> the next cycle shows IDLE, in_ready=1, out_valid=0, out_data=0; a following 0x81 transfer completes correctly.
REQ-034 Corrupted chain: insert an inverter in the chain model and send 0xA5 -> out_data=0x5A.
REQ-035 Back-to-back: send 0x00 then 0xFF with in_valid held high and out_ready=1 -> two out_valid pulses, carrying 0x00 then 0xFF, separated by WIDTH+CHAIN_DEPTH+2 cycles.
